// File: rtl/present_pkg.sv
// Shared types and constants for the PRESENT-80 core arbiter.
package present_pkg;

  localparam int unsigned PT_W     = 64;
  localparam int unsigned KEY_W    = 80;
  localparam int unsigned CORE_LAT = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [PT_W-1:0]  ptext;
  } operand_t;

endpackage

// File: rtl/present_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, else lowest set request.
module present_rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] masked;
  logic            found;

  always_comb begin
    masked = '0;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      masked[i] = req[i] && (IW'(i) >= ptr);
    end
    // Upper (not yet served) half wins; otherwise wrap to the lowest request.
    for (int i = 0; i < NREQ; i++) begin
      if (masked[i] && !found) begin
        onehot[i] = 1'b1;
        idx       = IW'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !found) begin
        onehot[i] = 1'b1;
        idx       = IW'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/present_arbiter.sv
// Round-robin sharing of one PRESENT-80 core between NREQ requesters, with a completion watchdog.
module present_arbiter
  import present_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 63
) (
  input  logic                    CK,
  input  logic                    RN,
  input  logic [NREQ-1:0]         req,
  input  logic [PT_W*NREQ-1:0]    ptext_in,
  input  logic [KEY_W*NREQ-1:0]   key_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [PT_W-1:0]         ctext,
  output logic                    err,
  output logic                    busy,
  output logic                    core_start,
  output logic [PT_W-1:0]         core_ptext,
  output logic [KEY_W-1:0]        core_key,
  input  logic                    core_ready,
  input  logic [PT_W-1:0]         core_ctext
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TMO + 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] owner_oh;
  logic [CW-1:0]   cnt;
  operand_t        op;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   ptr_nxt;
  operand_t        sel;

  present_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign ptr_nxt    = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
  assign core_ptext = op.ptext;
  assign core_key   = op.key;

  // Operand mux for the current winner.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel.ptext = ptext_in[i*PT_W +: PT_W];
        sel.key   = key_in[i*KEY_W +: KEY_W];
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner_oh   <= '0;
      cnt        <= '0;
      op         <= '0;
      gnt        <= '0;
      done       <= '0;
      ctext      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
    end else begin
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            op         <= sel;
            owner_oh   <= pick_oh;
            ptr        <= ptr_nxt;
            gnt        <= pick_oh;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A ready seen at count 0 is left over from the previous operation.
          if (core_ready && (cnt != '0)) begin
            ctext <= core_ctext;
            done  <= owner_oh;
            state <= ST_FINISH;
          end else if (cnt == CW'(TMO)) begin
            ctext <= '0;
            err   <= 1'b1;
            done  <= owner_oh;
            state <= ST_FINISH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_arbiter.sv
// Randomised bench for present_arbiter: PRESENT-80 core model plus a transaction-level arbiter model.
module tb_present_arbiter;
  import present_pkg::*;

  localparam int NREQ = 4;
  localparam int TMO  = 63;

  logic                  CK = 1'b0;
  logic                  RN = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [64*NREQ-1:0]    ptext_in = '0;
  logic [80*NREQ-1:0]    key_in = '0;
  logic [NREQ-1:0]       gnt, done;
  logic [63:0]           ctext, core_ptext;
  logic [79:0]           core_key;
  logic                  err, busy, core_start;
  logic                  core_ready;
  logic [63:0]           core_ctext;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  present_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
    .CK(CK), .RN(RN), .req(req), .ptext_in(ptext_in), .key_in(key_in),
    .gnt(gnt), .done(done), .ctext(ctext), .err(err), .busy(busy),
    .core_start(core_start), .core_ptext(core_ptext), .core_key(core_key),
    .core_ready(core_ready), .core_ctext(core_ctext)
  );

  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h2174_8FE3_DA09_B65C;
    return tbl[4*x +: 4];
  endfunction

  function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s, p;
    logic [79:0] kr;
    s  = pt;
    kr = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kr[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
      p = '0;
      for (int b = 0; b < 63; b++) p[(b*16) % 63] = s[b];
      p[63] = s[63];
      s = p;
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sbox(kr[79:76]);
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    return s ^ kr[79:16];
  endfunction

  // Core model: 0 normal, 1 never ready, 2 keeps an old ready one cycle past start.
  int          core_mode = 0;
  logic        c_run, c_hold;
  int          c_cnt;
  logic [63:0] c_res;

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      core_ready <= 1'b0;
      core_ctext <= '0;
      c_run      <= 1'b0;
      c_hold     <= 1'b0;
      c_cnt      <= 0;
      c_res      <= '0;
    end else if (core_start) begin
      c_run <= (core_mode != 1);
      c_cnt <= 0;
      c_res <= present80(core_ptext, core_key);
      if (core_mode == 2 && core_ready) c_hold <= 1'b1;
      else core_ready <= 1'b0;
    end else begin
      if (c_hold) begin
        c_hold     <= 1'b0;
        core_ready <= 1'b0;
      end
      if (c_run) begin
        if (c_cnt == CORE_LAT - 1) begin
          core_ready <= 1'b1;
          core_ctext <= c_res;
          c_run      <= 1'b0;
        end else begin
          c_cnt <= c_cnt + 1;
        end
      end
    end
  end

  // Arbiter model as a schedule: pick at edge P, grant in cycle P, done in cycle D, next pick from D+2.
  int          m_pick = -1, m_done = -1, m_free = 0, m_owner = 0, m_ptr = 0;
  bit          m_abort = 1'b0;
  logic [63:0] m_ctext = '0, m_res = '0, m_pt = '0;
  logic [79:0] m_key = '0;
  bit [NREQ-1:0] hold = '0;

  always @(negedge RN) begin
    m_pick = -1; m_done = -1; m_free = 0; m_ptr = 0; m_owner = 0;
    m_abort = 1'b0; m_ctext = '0; m_res = '0; m_pt = '0; m_key = '0;
  end

  always @(posedge CK) begin
    int w;
    bit f;
    cyc = cyc + 1;
    if (RN) begin
      if (cyc == m_done) m_ctext = m_res;
      if (cyc >= m_free && req != '0) begin
        w = 0; f = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          if (!f && req[(m_ptr + k) % NREQ]) begin
            w = (m_ptr + k) % NREQ;
            f = 1'b1;
          end
        end
        m_owner = w;
        m_pick  = cyc;
        m_pt    = ptext_in[w*64 +: 64];
        m_key   = key_in[w*80 +: 80];
        m_ptr   = (w + 1) % NREQ;
        if (core_mode == 1) begin
          m_done = cyc + TMO + 2; m_abort = 1'b1; m_res = '0;
        end else begin
          m_done = cyc + CORE_LAT + 2; m_abort = 1'b0; m_res = present80(m_pt, m_key);
        end
        m_free = m_done + 2;
      end
    end
  end

  // Requesters drop req once granted unless told to keep asking.
  always @(negedge CK) begin
    if (RN && m_pick >= 0 && cyc == m_pick && !hold[m_owner]) req[m_owner] = 1'b0;
  end

  logic [NREQ-1:0] e_oh;
  bit              on_p, on_d;
  always @(negedge CK) begin
    if (RN) begin
      on_p = (m_pick >= 0) && (cyc == m_pick);
      on_d = (m_pick >= 0) && (cyc == m_done);
      e_oh = NREQ'(1) << m_owner;
      chk("gnt",        gnt,        on_p ? e_oh : '0);
      chk("core_start", core_start, on_p);
      chk("done",       done,       on_d ? e_oh : '0);
      chk("err",        err,        on_d && m_abort);
      chk("busy",       busy,       (m_pick >= 0) && cyc >= m_pick && cyc <= m_done);
      chk("ctext",      ctext,      m_ctext);
      chk("core_ptext", core_ptext, m_pt);
      chk("core_key",   core_key,   m_key);
    end
  end

  task automatic run_one(input int i, input logic [63:0] pt, input logic [79:0] k,
                         output int c0, output int gc, output int dc,
                         output logic [63:0] cx, output logic ex, output logic [NREQ-1:0] dv);
    bit ok = 1'b0;
    gc = -1; dc = -1; cx = '0; ex = 1'b0; dv = '0;
    @(negedge CK);
    ptext_in[i*64 +: 64] = pt;
    key_in[i*80 +: 80]   = k;
    req[i] = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 150; n++) begin
      @(negedge CK);
      if (gnt[i]) gc = cyc;
      if (done != '0) begin
        dc = cyc; cx = ctext; ex = err; dv = done; ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge CK);
      if (req == '0 && (m_pick < 0 || cyc > m_done)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(negedge CK);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0, gc, dc, ng0, order_n, nd;
    int order[4];
    logic [63:0] cx, pt;
    logic [79:0] k;
    logic ex;
    logic [NREQ-1:0] dv;
    bit seen;

    // Reset state
    repeat (3) @(negedge CK);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", core_start, 0);
    chk("rst_ctext", ctext, 0);
    chk("rst_ptext", core_ptext, 0);
    chk("rst_key", core_key, 0);
    chk("vec_zero", present80(64'h0, 80'h0), 64'h5579C1387B228445);
    chk("vec_ones", present80({64{1'b1}}, {80{1'b1}}), 64'h3333DCD3213210D2);
    RN = 1'b1;
    repeat (2) @(negedge CK);

    // Contention from pointer 0
    @(negedge CK);
    for (int i = 0; i < NREQ; i++) begin
      ptext_in[i*64 +: 64] = {64{1'b1}};
      key_in[i*80 +: 80]   = {80{1'b1}};
    end
    req = '1;
    order_n = 0; nd = 0; cx = '0;
    for (int n = 0; n < 400 && nd < 4; n++) begin
      @(negedge CK);
      for (int i = 0; i < NREQ; i++) if (gnt[i] && order_n < 4) begin order[order_n] = i; order_n++; end
      if (done != '0) begin nd++; cx = ctext; end
    end
    chk("cont_ngnt", order_n, 4);
    for (int i = 0; i < 4; i++) chk("cont_order", order[i], i);
    chk("cont_ctext", cx, 64'h3333DCD3213210D2);
    wait_idle(200);

    // Single request, latency
    run_one(2, 64'h0, 80'h0, c0, gc, dc, cx, ex, dv);
    chk("single_gnt_lat", gc - c0, 1);
    chk("single_done_lat", dc - c0, 35);
    chk("single_done", dv, 4'b0100);
    chk("single_ctext", cx, 64'h5579C1387B228445);
    chk("single_err", ex, 0);
    wait_idle(200);

    // Fairness: req[0] kept high, req[3] raised once
    @(negedge CK);
    hold[0] = 1'b1;
    ptext_in[63:0] = 64'h0123_4567_89AB_CDEF;
    key_in[79:0]   = 80'h1;
    req[0] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin @(negedge CK); if (gnt[0]) seen = 1'b1; end
    chk("fair_first0", seen, 1);
    repeat (3) @(negedge CK);
    ptext_in[3*64 +: 64] = 64'hDEAD_BEEF_0000_0003;
    key_in[3*80 +: 80]   = 80'h3;
    req[3] = 1'b1;
    ng0 = 0; seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge CK);
      if (gnt[0]) ng0++;
      if (gnt[3]) begin seen = 1'b1; hold[0] = 1'b0; req[0] = 1'b0; end
    end
    chk("fair_gnt3", seen, 1);
    chk("fair_bound", ng0 <= 1, 1);
    hold[0] = 1'b0; req[0] = 1'b0;
    wait_idle(300);

    // Watchdog
    core_mode = 1;
    run_one(1, 64'h1111, 80'h2222, c0, gc, dc, cx, ex, dv);
    chk("wd_done", dv, 4'b0010);
    chk("wd_err", ex, 1);
    chk("wd_ctext", cx, 0);
    chk("wd_lat", dc - gc, TMO + 2);
    @(negedge CK);
    chk("wd_busy", busy, 0);
    core_mode = 0;
    wait_idle(50);
    pt = {$urandom, $urandom}; k = {$urandom, $urandom, 16'($urandom)};
    run_one(2, pt, k, c0, gc, dc, cx, ex, dv);
    chk("wd_next_ctext", cx, present80(pt, k));
    chk("wd_next_err", ex, 0);
    wait_idle(50);

    // Stale ready from previous operation
    core_mode = 2;
    pt = {$urandom, $urandom}; k = {$urandom, $urandom, 16'($urandom)};
    run_one(0, pt, k, c0, gc, dc, cx, ex, dv);
    chk("stale_lat", dc - gc, CORE_LAT + 2);
    chk("stale_ctext", cx, present80(pt, k));
    core_mode = 0;
    wait_idle(50);

    // Reset in WAIT
    @(negedge CK);
    ptext_in[3*64 +: 64] = 64'h5;
    key_in[3*80 +: 80]   = 80'h6;
    req[3] = 1'b1;
    gc = -1;
    for (int n = 0; n < 20 && gc < 0; n++) begin @(negedge CK); if (gnt[3]) gc = cyc; end
    chk("rst_mid_gnt", gc >= 0, 1);
    while (cyc < gc + 11) @(negedge CK);
    RN = 1'b0;
    req[3] = 1'b0;
    #1;
    chk("rmid_gnt", gnt, 0);
    chk("rmid_done", done, 0);
    chk("rmid_err", err, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_ctext", ctext, 0);
    chk("rmid_ptext", core_ptext, 0);
    chk("rmid_key", core_key, 0);
    for (int n = 0; n < 3; n++) begin @(negedge CK); chk("rmid_nodone", done, 0); end
    RN = 1'b1;
    pt = {$urandom, $urandom}; k = {$urandom, $urandom, 16'($urandom)};
    run_one(1, pt, k, c0, gc, dc, cx, ex, dv);
    chk("rpost_done", dv, 4'b0010);
    chk("rpost_ctext", cx, present80(pt, k));
    chk("rpost_lat", dc - c0, 35);
    wait_idle(50);

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      @(negedge CK);
      if ($urandom_range(0, 99) == 0) core_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 39) == 0) begin
          ptext_in[i*64 +: 64] = {$urandom, $urandom};
          key_in[i*80 +: 80]   = {$urandom, $urandom, 16'($urandom)};
          req[i] = 1'b1;
        end
      end
    end
    wait_idle(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
